// File: rtl/fetch_buffer_if.sv
// Fetch-buffer bus bundle: PC handshake, instruction-memory request/response and decode handshake.
// The fetch_buffer takes the master side; the environment (PC, memory, decode) takes the slave side.
interface fetch_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] FB_PC;
  logic              FB_PC_ADV;
  logic              FLUSH;
  logic              MEM_REQ;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic              MEM_GNT;
  logic              MEM_RVALID;
  logic [DATA_W-1:0] MEM_RDATA;
  logic              INSTR_VALID;
  logic              INSTR_READY;
  logic [DATA_W-1:0] INSTR;
  logic [ADDR_W-1:0] INSTR_PC;

  modport master (
    input  FB_PC, FLUSH, MEM_GNT, MEM_RVALID, MEM_RDATA, INSTR_READY,
    output FB_PC_ADV, MEM_REQ, MEM_ADDR, INSTR_VALID, INSTR, INSTR_PC
  );

  modport slave (
    output FB_PC, FLUSH, MEM_GNT, MEM_RVALID, MEM_RDATA, INSTR_READY,
    input  FB_PC_ADV, MEM_REQ, MEM_ADDR, INSTR_VALID, INSTR, INSTR_PC
  );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction-fetch front end: issues memory reads at the current PC, tags responses with their PC,
// queues {pc, instr} pairs for decode, and discards in-flight responses after a redirect.
module fetch_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic           FB_CLK,
  input  logic           FB_RST_N,
  fetch_buffer_if.master fb
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]        state, state_n;
  logic [CW-1:0]     cnt, outs, disc, disc_n;
  logic [CW:0]       used;
  logic [PW-1:0]     q_wr, q_rd, t_wr, t_rd;
  logic [DATA_W-1:0] q_instr [DEPTH];
  logic [ADDR_W-1:0] q_pc    [DEPTH];
  logic [ADDR_W-1:0] tag_mem [DEPTH];
  logic              req, adv, rsp, push, pop, head_valid;

  // Every granted request already holds a queue slot, so a response can always be written.
  assign used = {1'b0, cnt} + {1'b0, outs};
  assign req  = FB_RST_N && (state == ST_RUN) && !fb.FLUSH && (used < (CW+1)'(DEPTH));
  assign adv  = req && fb.MEM_GNT;
  // A response with nothing outstanding is a protocol error and is ignored entirely.
  assign rsp  = fb.MEM_RVALID && (outs != '0);
  assign push = rsp && !fb.FLUSH && (disc == '0);
  assign head_valid = (cnt != '0);
  assign pop  = head_valid && fb.INSTR_READY && !fb.FLUSH;

  assign fb.MEM_REQ     = req;
  assign fb.MEM_ADDR    = fb.FB_PC;
  assign fb.FB_PC_ADV   = adv;
  assign fb.INSTR_VALID = head_valid;
  assign fb.INSTR       = head_valid ? q_instr[q_rd] : '0;
  assign fb.INSTR_PC    = head_valid ? q_pc[q_rd]    : '0;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    disc_n = disc;
    if (fb.FLUSH) begin
      disc_n = outs + CW'(adv) - CW'(rsp);
    end else if (rsp && (disc != '0)) begin
      disc_n = disc - CW'(1);
    end
    state_n = (disc_n != '0) ? ST_DRAIN : ST_RUN;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge FB_CLK or negedge FB_RST_N) begin
    if (!FB_RST_N) begin
      state <= ST_RUN;
      cnt   <= '0;
      outs  <= '0;
      disc  <= '0;
      q_wr  <= '0;
      q_rd  <= '0;
      t_wr  <= '0;
      t_rd  <= '0;
    end else begin
      state <= state_n;
      disc  <= disc_n;
      outs  <= outs + CW'(adv) - CW'(rsp);
      if (adv) t_wr <= t_wr + PW'(1);
      if (rsp) t_rd <= t_rd + PW'(1);
      if (fb.FLUSH) begin
        cnt  <= '0;
        q_wr <= '0;
        q_rd <= '0;
      end else begin
        cnt <= cnt + CW'(push) - CW'(pop);
        if (push) q_wr <= q_wr + PW'(1);
        if (pop)  q_rd <= q_rd + PW'(1);
      end
    end
  end

  // NOTE: storage arrays are not reset; their contents are only observed through valid pointers/counts.
  always_ff @(posedge FB_CLK) begin
    if (adv) tag_mem[t_wr] <= fb.FB_PC;
    if (push) begin
      q_instr[q_wr] <= fb.MEM_RDATA;
      q_pc[q_wr]    <= tag_mem[t_rd];
    end
  end

endmodule
